fetch_stage: RTL

- Instruction-fetch front end of the 32-bit pipeline.
- Holds the PC and issues one-at-a-time word reads to instruction memory.
- Registers the returned instruction into the IF/ID boundary (instr, pc, pc+4, valid).
- Decode and the downstream next-PC mux2 instances (branch/jump select) consume these outputs; their selected target comes back as redirect_pc.

---
 rtl/fetch_stage_if.sv | 49 ++++
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus bundle between the fetch stage, instruction memory and
// decode. The master modport is the fetch stage itself; the slave modport is
// the environment (memory responder + decode/next-PC logic).
// When FETCH_PERF_EN is defined the performance counter outputs are included.
interface fetch_stage_if #(
  parameter int unsigned WIDTH = 32
);
  // Control from decode / next-PC logic
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  // Instruction memory read channel
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  // IF/ID boundary
  logic             if_valid;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0]      perf_fetch_cnt;
  logic [31:0]      perf_stall_cnt;
  logic [31:0]      perf_flush_cnt;

  modport master (
    input  stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    input  stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Holds the PC, issues one word read
// at a time to instruction memory and registers the returned word into the
// IF/ID boundary. A one-entry skid register absorbs a response that arrives
// while decode is stalled. Redirects flush IF/ID and drop any response still
// in flight for the old path.
// Optional feature: define FETCH_PERF_EN to add saturating fetch/stall/flush
// performance counters.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master fs
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] pc_q,         pc_d;
  logic             req_q,        req_d;
  logic [WIDTH-1:0] addr_q,       addr_d;
  logic             out_q,        out_d;      // a request is outstanding
  logic             discard_q,    discard_d;  // drop the next response
  logic             if_valid_q,   if_valid_d;
  logic [WIDTH-1:0] if_instr_q,   if_instr_d;
  logic [WIDTH-1:0] if_pc_q,      if_pc_d;
  logic [WIDTH-1:0] if_pc4_q,     if_pc4_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc_q,    skid_pc_d;
`ifdef FETCH_PERF_EN
  logic [31:0]      fetch_cnt_q,  fetch_cnt_d;
  logic [31:0]      stall_cnt_q,  stall_cnt_d;
  logic [31:0]      flush_cnt_q,  flush_cnt_d;
`endif

  logic             accepted;   // request accepted this cycle
  logic             rsp;        // response belonging to an outstanding request
  logic             if_free;
  logic             load;
  logic [WIDTH-1:0] load_instr;
  logic [WIDTH-1:0] load_pc;

  // A response with nothing outstanding (e.g. a late one after reset) is ignored.
  assign accepted = req_q && !out_q;
  assign rsp      = fs.imem_rvalid && out_q;
  assign if_free  = !if_valid_q || !fs.stall;

  // Next-state logic for the fetch FSM, IF/ID register and skid entry.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_d        = out_q;
    discard_d    = discard_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pc4_d     = if_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load         = 1'b0;
    load_instr   = '0;
    load_pc      = '0;

    if (rsp) begin
      out_d = 1'b0;
    end else if (accepted) begin
      out_d = 1'b1;
    end

    // IF/ID drains to a bubble unless decode is holding a live entry.
    if (!(fs.stall && if_valid_q)) begin
      if_valid_d = 1'b0;
    end

    if (fs.redirect) begin
      state_d      = ST_REQ;
      pc_d         = fs.redirect_pc & ~WIDTH'(3);
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      // A response landing in the redirect cycle is simply dropped; only a
      // request still waiting needs its future response discarded.
      discard_d    = (out_q || accepted) && !rsp;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (rsp) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else if (if_free) begin
              load       = 1'b1;
              load_instr = fs.imem_rdata;
              load_pc    = pc_q;
              pc_d       = pc_q + WIDTH'(4);
            end else begin
              skid_valid_d = 1'b1;
              skid_instr_d = fs.imem_rdata;
              skid_pc_d    = pc_q;
              pc_d         = pc_q + WIDTH'(4);
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!fs.stall && skid_valid_q) begin
            load         = 1'b1;
            load_instr   = skid_instr_q;
            load_pc      = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = ST_REQ;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (load) begin
      if_valid_d = 1'b1;
      if_instr_d = load_instr;
      if_pc_d    = load_pc;
      if_pc4_d   = load_pc + WIDTH'(4);
    end

    // Request outputs are registered from the next state so they are glitch free.
    req_d  = (state_d == ST_REQ) && !discard_d;
    addr_d = pc_d;
  end

`ifdef FETCH_PERF_EN
  // Saturating performance counter increments.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (fs.stall && if_valid_q && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (fs.redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end
`endif

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      out_q        <= 1'b0;
      discard_q    <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc4_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      out_q        <= out_d;
      discard_q    <= discard_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc4_q     <= if_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
`ifdef FETCH_PERF_EN
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  assign fs.imem_req    = req_q;
  assign fs.imem_addr   = addr_q;
  assign fs.if_valid    = if_valid_q;
  assign fs.if_instr    = if_instr_q;
  assign fs.if_pc       = if_pc_q;
  assign fs.if_pc_plus4 = if_pc4_q;
`ifdef FETCH_PERF_EN
  assign fs.perf_fetch_cnt = fetch_cnt_q;
  assign fs.perf_stall_cnt = stall_cnt_q;
  assign fs.perf_flush_cnt = flush_cnt_q;
`endif

endmodule
